execute_sb: RTL and testbench
=============================

# execute_sb

Parametrised execute stage for the in-order RISC-V pipeline, between decode/register-read and memory. It selects ALU operands, computes the ALU result and branch decision, and registers control and data for the memory stage. It tracks up to SB_DEPTH in-flight stores in a FIFO to detect load-after-store address hazards. This replaces single-previous-store tracking with a tracked depth set by a parameter and stores that retire on commit.

## Interface
- XLEN, 32: datapath width.
- SB_DEPTH, 4: store-tracking entries; power of two, ≥2.
- CMP_LSB, 2: address bits below this are ignored in hazard compare (word granularity).
- clk  in  1: clock, rising edge.
- rst  in  1: reset, asynchronous, active-high.
- valid_i  in  1: decode presents an instruction.
- ready_o  out  1: instruction accepted this cycle; equals !stall_o.
- flush_i  in  1: kill the incoming instruction (redirect).
- sel_rd_i, alu_op_i, alu_src1_i, alu_src2_i, mem_re_i, mem_we_i, mem_size_i, imm_i, branch_i, jump_i, rs1_i, rs2_i, pc_i  in: decoded fields; widths 5 / alu_op_e / alu_src_e ×2 / 1 / 1 / data_size_e / XLEN ×4 for imm, rs1, rs2 and pc.
- store_commit_i  in  1: memory stage has written the oldest tracked store.
- valid_o  out  1: memory-stage outputs hold a real instruction.
- sel_rd_o, mem_re_o, mem_we_o, mem_size_o, alu_result_o, rs2_o  out: registered copies; widths 5 / 1 / 1 / data_size_e / XLEN / XLEN.
- branch_taken_o  out  1: combinational; (branch_i & alu_result[0] | jump_i) & valid_i & !flush_i.
- stall_o  out  1: combinational hazard stall.
- sb_count_o  out  $clog2(SB_DEPTH)+1: occupied entries.
- fwd_valid_o, fwd_data_o  out  1 / XLEN: forwarding result; present only with EXEC_STORE_FWD_EN.

## Operation
- Operands come from a mux over IMM, RS1, RS2 and PC. Unlisted encodings select 0. Each mux drives only its own operand.
- An instruction is live when valid_i & !flush_i.
- Hazard condition: the instruction is live, mem_re_i=1, and some valid entry has addr[XLEN-1:CMP_LSB] == alu_result[XLEN-1:CMP_LSB].
- Full condition: the instruction is live, mem_we_i=1, the buffer is full, and store_commit_i=0. This raises stall_o.
- stall_o = hazard | full.
- Accept: the instruction is live and stall_o=0.
  - On accept, all outputs load next edge with valid_o=1.
  - On accept of a store, the FIFO pushes {alu_result, rs2_i, mem_size_i}.
- No accept:
  - valid_o=0, and sel_rd_o, mem_re_o, mem_we_o and mem_size_o load 0 (bubble).
  - rs2_o and alu_result_o hold their values.
- store_commit_i pops the oldest entry. On an empty buffer it is ignored; count never underflows.
- Push and pop in the same cycle: count unchanged. When full, push is legal only with pop.
- The FIFO uses a circular buffer; read and write pointers wrap modulo SB_DEPTH.
- A committing entry still participates in the compare that cycle (conservative stall).
- flush_i never alters the buffer; stores already accepted remain tracked until committed.

## Timing
- Latency: 1 cycle from accept to registered outputs.
- stall_o, ready_o and branch_taken_o are combinational from the inputs and buffer state; there are no registered-to-output paths beyond that.
- A stalled load re-evaluates every cycle. It is accepted in the cycle after the matching entry pops.
- Reset values (all outputs and state): valid_o, sel_rd_o, mem_re_o, mem_we_o, mem_size_o, alu_result_o, rs2_o, fwd_valid_o and fwd_data_o are 0. Pointers, count and entry valids are 0.
- Reset asserted mid-stall or with a full buffer clears everything immediately; the first cycle after deassertion sees an empty buffer.

## Configuration
- EXEC_STORE_FWD_EN defined:
  - A load whose youngest matching entry has an identical full address and mem_size WORD does not stall.
  - On accept, fwd_valid_o=1 and fwd_data_o=entry data are registered.
  - Any other match (older-only match, sub-word size, partial address) stalls as usual.
- EXEC_STORE_FWD_EN not defined:
  - Entries omit data storage, and the fwd ports are absent.
  - Every match stalls.

## Structure
- The constants package holds alu_op_e, alu_src_e, data_size_e, and a new sb_entry_t struct {addr, data, size}.
- Sub-module store_addr_buffer contains:
  - the FIFO (push/pop/count/full/empty);
  - a parallel compare producing a hit flag and, under EXEC_STORE_FWD_EN, youngest-hit data and size.
- The existing alu is instantiated unchanged.

## Test plan
- Store to 0x100, then load from 0x104 the next cycle → no stall; valid_o=1 on both; sb_count_o=1.
- Store to 0x100, then load from 0x102 (no fwd) → stall_o=1 and valid_o=0 until store_commit_i. The load is accepted the cycle after the pop.
- Four stores with SB_DEPTH=4 and no commits, then a fifth store → stall_o=1. Asserting store_commit_i the same cycle accepts the store with count staying 4. Check pointer wrap across 8 pushes.
- With EXEC_STORE_FWD_EN: SW 0xDEADBEEF to 0x200, then LW 0x200 → no stall; fwd_valid_o=1, fwd_data_o=0xDEADBEEF. LB from 0x200 → stall.
- Store with flush_i=1 → not pushed, valid_o=0. store_commit_i on an empty buffer → sb_count_o stays 0.
- rst pulsed while a load stalls with 3 entries → all outputs 0 during reset; count 0 after; the load is accepted on the first post-reset cycle.

Source files
------------

// File: rtl/execute_sb_pkg.sv
// Shared types for the execute stage and its store-address buffer.
// EXEC_STORE_FWD_EN adds a data field to each tracked store entry.
package execute_sb_pkg;

    // Store entries are sized to this width; the execute stage XLEN must match it.
    localparam int SB_XLEN = 32;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL,
        ALU_SRA, ALU_SLT, ALU_SLTU, ALU_EQ, ALU_NE, ALU_GE, ALU_GEU
    } alu_op_e;

    typedef enum logic [1:0] {
        SRC_IMM, SRC_RS1, SRC_RS2, SRC_PC
    } alu_src_e;

    typedef enum logic [1:0] {
        SIZE_BYTE, SIZE_HALF, SIZE_WORD
    } data_size_e;

    typedef struct packed {
        logic [SB_XLEN-1:0] addr;
`ifdef EXEC_STORE_FWD_EN
        logic [SB_XLEN-1:0] data;
`endif
        data_size_e         size;
    } sb_entry_t;

endpackage

// File: rtl/execute_sb_if.sv
// Decode-to-execute bundle: decoded fields in, handshake/stall/branch back.
interface execute_sb_if
    import execute_sb_pkg::*;
#(
    parameter int XLEN = 32
);
    logic             valid_i;
    logic             ready_o;
    logic             flush_i;
    logic [4:0]       sel_rd_i;
    alu_op_e          alu_op_i;
    alu_src_e         alu_src1_i;
    alu_src_e         alu_src2_i;
    logic             mem_re_i;
    logic             mem_we_i;
    data_size_e       mem_size_i;
    logic [XLEN-1:0]  imm_i;
    logic             branch_i;
    logic             jump_i;
    logic [XLEN-1:0]  rs1_i;
    logic [XLEN-1:0]  rs2_i;
    logic [XLEN-1:0]  pc_i;
    logic             stall_o;
    logic             branch_taken_o;

    modport master (
        output valid_i, flush_i, sel_rd_i, alu_op_i, alu_src1_i, alu_src2_i,
               mem_re_i, mem_we_i, mem_size_i, imm_i, branch_i, jump_i,
               rs1_i, rs2_i, pc_i,
        input  ready_o, stall_o, branch_taken_o
    );

    modport slave (
        input  valid_i, flush_i, sel_rd_i, alu_op_i, alu_src1_i, alu_src2_i,
               mem_re_i, mem_we_i, mem_size_i, imm_i, branch_i, jump_i,
               rs1_i, rs2_i, pc_i,
        output ready_o, stall_o, branch_taken_o
    );
endinterface

// File: rtl/execute_sb_alu.sv
// Pipeline ALU. Compare ops return 0/1 in bit 0 for branch resolution.
module alu
    import execute_sb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  alu_op_e         op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic [XLEN-1:0] result_o
);
    localparam int SHW = $clog2(XLEN);

    // Pure combinational result select.
    always_comb begin
        result_o = '0;
        case (op_i)
            ALU_ADD:  result_o = a_i + b_i;
            ALU_SUB:  result_o = a_i - b_i;
            ALU_AND:  result_o = a_i & b_i;
            ALU_OR:   result_o = a_i | b_i;
            ALU_XOR:  result_o = a_i ^ b_i;
            ALU_SLL:  result_o = a_i << b_i[SHW-1:0];
            ALU_SRL:  result_o = a_i >> b_i[SHW-1:0];
            ALU_SRA:  result_o = $signed(a_i) >>> b_i[SHW-1:0];
            ALU_SLT:  result_o = {{(XLEN-1){1'b0}}, $signed(a_i) < $signed(b_i)};
            ALU_SLTU: result_o = {{(XLEN-1){1'b0}}, a_i < b_i};
            ALU_EQ:   result_o = {{(XLEN-1){1'b0}}, a_i == b_i};
            ALU_NE:   result_o = {{(XLEN-1){1'b0}}, a_i != b_i};
            ALU_GE:   result_o = {{(XLEN-1){1'b0}}, $signed(a_i) >= $signed(b_i)};
            ALU_GEU:  result_o = {{(XLEN-1){1'b0}}, a_i >= b_i};
            default:  result_o = '0;
        endcase
    end
endmodule

// File: rtl/execute_sb_store_addr_buffer.sv
// Circular FIFO of in-flight stores with a parallel word-address compare.
// Under EXEC_STORE_FWD_EN it also reports data/size/full-address match of
// the youngest hitting entry so the top can forward instead of stalling.
module store_addr_buffer
    import execute_sb_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int SB_DEPTH = 4,
    parameter int CMP_LSB  = 2,
    localparam int PW      = $clog2(SB_DEPTH),
    localparam int CW      = PW + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push_i,
    input  sb_entry_t       push_entry_i,
    input  logic            pop_i,
    input  logic [XLEN-1:0] cmp_addr_i,
    output logic            hit_o,
`ifdef EXEC_STORE_FWD_EN
    output logic            yng_full_eq_o,
    output data_size_e      yng_size_o,
    output logic [XLEN-1:0] yng_data_o,
`endif
    output logic [CW-1:0]   count_o,
    output logic            full_o
);
    sb_entry_t             entries_q [SB_DEPTH];
    sb_entry_t             entries_d [SB_DEPTH];
    logic [SB_DEPTH-1:0]   valid_q, valid_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  empty, pop_eff, push_eff;
    logic [PW-1:0]         idx;

    assign empty    = (count_q == '0);
    assign full_o   = (count_q == CW'(SB_DEPTH));
    assign count_o  = count_q;
    assign pop_eff  = pop_i & ~empty;
    assign push_eff = push_i & (~full_o | pop_eff);

    // Next-state for pointers, count and entry storage.
    always_comb begin
        entries_d = entries_q;
        valid_d   = valid_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (pop_eff) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + 1'b1;
        end
        if (push_eff) begin
            entries_d[wr_ptr_q] = push_entry_i;
            valid_d[wr_ptr_q]   = 1'b1;
            wr_ptr_d            = wr_ptr_q + 1'b1;
        end
        case ({push_eff, pop_eff})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Compare oldest to youngest so the last hit found is the youngest.
    always_comb begin
        hit_o = 1'b0;
        idx   = '0;
`ifdef EXEC_STORE_FWD_EN
        yng_full_eq_o = 1'b0;
        yng_size_o    = SIZE_BYTE;
        yng_data_o    = '0;
`endif
        for (int i = 0; i < SB_DEPTH; i++) begin
            idx = rd_ptr_q + PW'(i);
            if (valid_q[idx] &&
                entries_q[idx].addr[XLEN-1:CMP_LSB] == cmp_addr_i[XLEN-1:CMP_LSB]) begin
                hit_o = 1'b1;
`ifdef EXEC_STORE_FWD_EN
                yng_full_eq_o = (entries_q[idx].addr == cmp_addr_i);
                yng_size_o    = entries_q[idx].size;
                yng_data_o    = entries_q[idx].data;
`endif
            end
        end
    end

    // Buffer state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SB_DEPTH; i++) entries_q[i] <= '0;
            valid_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            entries_q <= entries_d;
            valid_q   <= valid_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end
endmodule

// File: rtl/execute_sb.sv
// Execute stage: operand select, ALU, branch decision, load-after-store
// hazard stall against tracked stores, and memory-stage registers.
// Optional store-to-load forwarding is enabled by EXEC_STORE_FWD_EN.
module execute_sb
    import execute_sb_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int SB_DEPTH = 4,
    parameter int CMP_LSB  = 2,
    localparam int CW      = $clog2(SB_DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst,
    execute_sb_if.slave     dec,
    input  logic            store_commit_i,
    output logic            valid_o,
    output logic [4:0]      sel_rd_o,
    output logic            mem_re_o,
    output logic            mem_we_o,
    output data_size_e      mem_size_o,
    output logic [XLEN-1:0] alu_result_o,
    output logic [XLEN-1:0] rs2_o,
`ifdef EXEC_STORE_FWD_EN
    output logic            fwd_valid_o,
    output logic [XLEN-1:0] fwd_data_o,
`endif
    output logic [CW-1:0]   sb_count_o
);
    logic [XLEN-1:0] op_a, op_b, alu_result;
    logic            live, hit, full, hazard, full_stall, stall, accept, fwd_ok;
    sb_entry_t       push_entry;

    logic            valid_q, valid_d, mem_re_q, mem_re_d, mem_we_q, mem_we_d;
    logic [4:0]      sel_rd_q, sel_rd_d;
    data_size_e      mem_size_q, mem_size_d;
    logic [XLEN-1:0] alu_result_q, alu_result_d, rs2_q, rs2_d;

    function automatic logic [XLEN-1:0] pick(input alu_src_e s, input logic [XLEN-1:0] imm,
                                             input logic [XLEN-1:0] rs1, input logic [XLEN-1:0] rs2,
                                             input logic [XLEN-1:0] pc);
        case (s)
            SRC_IMM: return imm;
            SRC_RS1: return rs1;
            SRC_RS2: return rs2;
            SRC_PC:  return pc;
            default: return '0;
        endcase
    endfunction

    assign op_a = pick(dec.alu_src1_i, dec.imm_i, dec.rs1_i, dec.rs2_i, dec.pc_i);
    assign op_b = pick(dec.alu_src2_i, dec.imm_i, dec.rs1_i, dec.rs2_i, dec.pc_i);

    alu #(.XLEN(XLEN)) u_alu (
        .op_i     (dec.alu_op_i),
        .a_i      (op_a),
        .b_i      (op_b),
        .result_o (alu_result)
    );

`ifdef EXEC_STORE_FWD_EN
    logic            yng_full_eq;
    data_size_e      yng_size;
    logic [XLEN-1:0] yng_data;
    logic            fwd_valid_q, fwd_valid_d;
    logic [XLEN-1:0] fwd_data_q, fwd_data_d;
`endif

    always_comb begin
        push_entry      = '0;
        push_entry.addr = alu_result;
        push_entry.size = dec.mem_size_i;
`ifdef EXEC_STORE_FWD_EN
        push_entry.data = dec.rs2_i;
`endif
    end

    store_addr_buffer #(.XLEN(XLEN), .SB_DEPTH(SB_DEPTH), .CMP_LSB(CMP_LSB)) u_sab (
        .clk           (clk),
        .rst           (rst),
        .push_i        (accept & dec.mem_we_i),
        .push_entry_i  (push_entry),
        .pop_i         (store_commit_i),
        .cmp_addr_i    (alu_result),
        .hit_o         (hit),
`ifdef EXEC_STORE_FWD_EN
        .yng_full_eq_o (yng_full_eq),
        .yng_size_o    (yng_size),
        .yng_data_o    (yng_data),
`endif
        .count_o       (sb_count_o),
        .full_o        (full)
    );

`ifdef EXEC_STORE_FWD_EN
    // Forward only a whole-word load from a whole-word store at the same address.
    assign fwd_ok = hit & yng_full_eq & (yng_size == SIZE_WORD) & (dec.mem_size_i == SIZE_WORD);
`else
    assign fwd_ok = 1'b0;
`endif

    assign live       = dec.valid_i & ~dec.flush_i;
    assign hazard     = live & dec.mem_re_i & hit & ~fwd_ok;
    assign full_stall = live & dec.mem_we_i & full & ~store_commit_i;
    assign stall      = hazard | full_stall;
    assign accept     = live & ~stall;

    assign dec.stall_o        = stall;
    assign dec.ready_o        = ~stall;
    assign dec.branch_taken_o = ((dec.branch_i & alu_result[0]) | dec.jump_i) & live;

    // Load on accept; otherwise bubble control and hold the datapath values.
    always_comb begin
        valid_d      = accept;
        sel_rd_d     = accept ? dec.sel_rd_i   : 5'd0;
        mem_re_d     = accept & dec.mem_re_i;
        mem_we_d     = accept & dec.mem_we_i;
        mem_size_d   = accept ? dec.mem_size_i : SIZE_BYTE;
        alu_result_d = accept ? alu_result     : alu_result_q;
        rs2_d        = accept ? dec.rs2_i      : rs2_q;
`ifdef EXEC_STORE_FWD_EN
        fwd_valid_d  = accept & dec.mem_re_i & fwd_ok;
        fwd_data_d   = fwd_valid_d ? yng_data  : fwd_data_q;
`endif
    end

    // Memory-stage pipeline registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q      <= 1'b0;
            sel_rd_q     <= '0;
            mem_re_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_size_q   <= SIZE_BYTE;
            alu_result_q <= '0;
            rs2_q        <= '0;
`ifdef EXEC_STORE_FWD_EN
            fwd_valid_q  <= 1'b0;
            fwd_data_q   <= '0;
`endif
        end else begin
            valid_q      <= valid_d;
            sel_rd_q     <= sel_rd_d;
            mem_re_q     <= mem_re_d;
            mem_we_q     <= mem_we_d;
            mem_size_q   <= mem_size_d;
            alu_result_q <= alu_result_d;
            rs2_q        <= rs2_d;
`ifdef EXEC_STORE_FWD_EN
            fwd_valid_q  <= fwd_valid_d;
            fwd_data_q   <= fwd_data_d;
`endif
        end
    end

    assign valid_o      = valid_q;
    assign sel_rd_o     = sel_rd_q;
    assign mem_re_o     = mem_re_q;
    assign mem_we_o     = mem_we_q;
    assign mem_size_o   = mem_size_q;
    assign alu_result_o = alu_result_q;
    assign rs2_o        = rs2_q;
`ifdef EXEC_STORE_FWD_EN
    assign fwd_valid_o  = fwd_valid_q;
    assign fwd_data_o   = fwd_data_q;
`endif
endmodule

// File: tb/tb_execute_sb.sv
// Directed bench for execute_sb with default parameters (XLEN 32, depth 4).
module tb_execute_sb;
    import execute_sb_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        store_commit;
    logic        valid_o, mem_re_o, mem_we_o;
    logic [4:0]  sel_rd_o;
    data_size_e  mem_size_o;
    logic [31:0] alu_result_o, rs2_o;
    logic [2:0]  sb_count_o;
`ifdef EXEC_STORE_FWD_EN
    logic        fwd_valid_o;
    logic [31:0] fwd_data_o;
`endif
    int checks = 0;
    int errors = 0;

    execute_sb_if #(.XLEN(32)) ifc ();

    execute_sb #(.XLEN(32), .SB_DEPTH(4), .CMP_LSB(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .dec            (ifc.slave),
        .store_commit_i (store_commit),
        .valid_o        (valid_o),
        .sel_rd_o       (sel_rd_o),
        .mem_re_o       (mem_re_o),
        .mem_we_o       (mem_we_o),
        .mem_size_o     (mem_size_o),
        .alu_result_o   (alu_result_o),
        .rs2_o          (rs2_o),
`ifdef EXEC_STORE_FWD_EN
        .fwd_valid_o    (fwd_valid_o),
        .fwd_data_o     (fwd_data_o),
`endif
        .sb_count_o     (sb_count_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one instruction at the falling edge: rs1 + imm(0) address, rs2 as data.
    task automatic op(input logic v, input logic f, input logic re, input logic we,
                      input data_size_e sz, input logic [31:0] addr, input logic [31:0] data,
                      input logic cm);
        @(negedge clk);
        ifc.valid_i    = v;
        ifc.flush_i    = f;
        ifc.sel_rd_i   = 5'd7;
        ifc.alu_op_i   = ALU_ADD;
        ifc.alu_src1_i = SRC_RS1;
        ifc.alu_src2_i = SRC_IMM;
        ifc.mem_re_i   = re;
        ifc.mem_we_i   = we;
        ifc.mem_size_i = sz;
        ifc.imm_i      = 32'h0;
        ifc.branch_i   = 1'b0;
        ifc.jump_i     = 1'b0;
        ifc.rs1_i      = addr;
        ifc.rs2_i      = data;
        ifc.pc_i       = 32'h0;
        store_commit   = cm;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        op(0, 0, 0, 0, SIZE_BYTE, 0, 0, 0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {31'b0, valid_o}, 0);
        chk("rst_count", {29'b0, sb_count_o}, 0);
        chk("rst_alu", alu_result_o, 0);
        chk("rst_rs2", rs2_o, 0);
        chk("rst_ctl", {25'b0, sel_rd_o, mem_re_o, mem_we_o}, 0);
`ifdef EXEC_STORE_FWD_EN
        chk("rst_fwd", {fwd_valid_o, fwd_data_o[30:0]}, 0);
`endif
        @(negedge clk);
        rst = 1'b0;

        // Store then load to a different word: no stall.
        op(1, 0, 0, 1, SIZE_WORD, 32'h100, 32'h1111_1111, 0);
        chk("st_stall", {31'b0, ifc.stall_o}, 0);
        tick();
        chk("st_valid", {31'b0, valid_o}, 1);
        chk("st_we", {31'b0, mem_we_o}, 1);
        chk("st_alu", alu_result_o, 32'h100);
        chk("st_rs2", rs2_o, 32'h1111_1111);
        chk("st_count", {29'b0, sb_count_o}, 1);
        op(1, 0, 1, 0, SIZE_WORD, 32'h104, 0, 0);
        chk("ld104_stall", {31'b0, ifc.stall_o}, 0);
        tick();
        chk("ld104_valid", {31'b0, valid_o}, 1);
        chk("ld104_alu", alu_result_o, 32'h104);
        chk("ld104_count", {29'b0, sb_count_o}, 1);

        // Same-word load stalls until the store commits.
        op(1, 0, 1, 0, SIZE_HALF, 32'h102, 0, 0);
        chk("ld102_stall", {31'b0, ifc.stall_o}, 1);
        chk("ld102_ready", {31'b0, ifc.ready_o}, 0);
        tick();
        chk("ld102_bubble", {30'b0, valid_o, mem_re_o}, 0);
        chk("ld102_hold", alu_result_o, 32'h104);
        op(1, 0, 1, 0, SIZE_HALF, 32'h102, 0, 1);
        chk("ld102_commit_stall", {31'b0, ifc.stall_o}, 1);
        tick();
        chk("ld102_popcount", {29'b0, sb_count_o}, 0);
        chk("ld102_still_bubble", {31'b0, valid_o}, 0);
        op(1, 0, 1, 0, SIZE_HALF, 32'h102, 0, 0);
        chk("ld102_free", {31'b0, ifc.stall_o}, 0);
        tick();
        chk("ld102_valid", {31'b0, valid_o}, 1);
        chk("ld102_alu", alu_result_o, 32'h102);

        // Branch decision and SUB with PC operand.
        op(1, 0, 0, 0, SIZE_BYTE, 32'd5, 32'd5, 0);
        ifc.branch_i = 1'b1; ifc.alu_op_i = ALU_EQ; ifc.alu_src2_i = SRC_RS2;
        #1;
        chk("beq_taken", {31'b0, ifc.branch_taken_o}, 1);
        ifc.rs2_i = 32'd6;
        #1;
        chk("beq_not", {31'b0, ifc.branch_taken_o}, 0);
        op(1, 0, 0, 0, SIZE_BYTE, 32'd10, 0, 0);
        ifc.alu_op_i = ALU_SUB; ifc.alu_src2_i = SRC_PC; ifc.pc_i = 32'd3;
        tick();
        chk("sub_pc", alu_result_o, 32'd7);
        chk("sub_rd", {27'b0, sel_rd_o}, 7);

        // Fill, full stall, push-with-pop, pointer wrap across 8 pushes.
        for (int i = 0; i < 4; i++) begin
            op(1, 0, 0, 1, SIZE_WORD, 32'h300 + 32'(i) * 32'h10, 32'(i), 0);
            tick();
        end
        chk("fill_count", {29'b0, sb_count_o}, 4);
        op(1, 0, 0, 1, SIZE_WORD, 32'h340, 0, 0);
        chk("full_stall", {31'b0, ifc.stall_o}, 1);
        tick();
        chk("full_bubble", {31'b0, valid_o}, 0);
        chk("full_count", {29'b0, sb_count_o}, 4);
        op(1, 0, 0, 1, SIZE_WORD, 32'h340, 0, 1);
        chk("full_pop_stall", {31'b0, ifc.stall_o}, 0);
        tick();
        chk("full_pop_valid", {31'b0, valid_o}, 1);
        chk("full_pop_count", {29'b0, sb_count_o}, 4);
        chk("full_pop_alu", alu_result_o, 32'h340);
        for (int i = 5; i < 8; i++) begin
            op(1, 0, 0, 1, SIZE_WORD, 32'h300 + 32'(i) * 32'h10, 32'(i), 1);
            tick();
        end
        chk("wrap_count", {29'b0, sb_count_o}, 4);
        op(1, 0, 1, 0, SIZE_HALF, 32'h370, 0, 0);
        chk("wrap_young_hit", {31'b0, ifc.stall_o}, 1);
        op(1, 0, 1, 0, SIZE_HALF, 32'h343, 0, 0);
        chk("wrap_old_hit", {31'b0, ifc.stall_o}, 1);
        op(1, 0, 1, 0, SIZE_WORD, 32'h344, 0, 0);
        chk("word_boundary", {31'b0, ifc.stall_o}, 0);
        op(1, 0, 1, 0, SIZE_WORD, 32'h300, 0, 0);
        chk("popped_no_hit", {31'b0, ifc.stall_o}, 0);
        tick();
        chk("popped_valid", {31'b0, valid_o}, 1);
        for (int i = 0; i < 5; i++) begin
            op(0, 0, 0, 0, SIZE_BYTE, 0, 0, 1);
            tick();
        end
        chk("drain_count", {29'b0, sb_count_o}, 0);

        // Flushed store is not pushed; jump under flush not taken.
        op(1, 1, 0, 1, SIZE_WORD, 32'h500, 0, 0);
        ifc.jump_i = 1'b1;
        #1;
        chk("flush_br", {31'b0, ifc.branch_taken_o}, 0);
        tick();
        chk("flush_bubble", {30'b0, valid_o, mem_we_o}, 0);
        chk("flush_count", {29'b0, sb_count_o}, 0);

`ifdef EXEC_STORE_FWD_EN
        op(1, 0, 0, 1, SIZE_WORD, 32'h200, 32'hDEAD_BEEF, 0);
        tick();
        op(1, 0, 1, 0, SIZE_WORD, 32'h200, 0, 0);
        chk("fwd_lw_stall", {31'b0, ifc.stall_o}, 0);
        tick();
        chk("fwd_valid", {31'b0, fwd_valid_o}, 1);
        chk("fwd_data", fwd_data_o, 32'hDEAD_BEEF);
        op(1, 0, 1, 0, SIZE_BYTE, 32'h200, 0, 0);
        chk("fwd_lb_stall", {31'b0, ifc.stall_o}, 1);
        op(0, 0, 0, 0, SIZE_BYTE, 0, 0, 1);
        tick();
        chk("fwd_drain", {29'b0, sb_count_o}, 0);
`endif

        // Reset while a load stalls against three entries.
        for (int i = 0; i < 3; i++) begin
            op(1, 0, 0, 1, SIZE_WORD, 32'h400 + 32'(i) * 32'h10, 32'hA0 + 32'(i), 0);
            tick();
        end
        op(1, 0, 1, 0, SIZE_HALF, 32'h410, 0, 0);
        chk("rst_mid_stall", {31'b0, ifc.stall_o}, 1);
        tick();
        chk("rst_mid_count", {29'b0, sb_count_o}, 3);
        rst = 1'b1;
        #1;
        chk("rst_async_count", {29'b0, sb_count_o}, 0);
        chk("rst_async_data", alu_result_o | rs2_o, 0);
        chk("rst_async_stall", {31'b0, ifc.stall_o}, 0);
        tick();
        chk("rst_hold_valid", {31'b0, valid_o}, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("post_rst_valid", {31'b0, valid_o}, 1);
        chk("post_rst_alu", alu_result_o, 32'h410);
        chk("post_rst_count", {29'b0, sb_count_o}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1);
    end
endmodule
